// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Start/busy/done handshake; the borrow is carried in a register between bits.
// Optional macro SERIAL_SUBTRACTOR_ABS_EN adds a FIX cycle that turns a negative
// result into its magnitude (borrow_out still flags the sign).
module serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] One     = WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone, StFix} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;
  logic             zero_q, zero_d;

  logic             d_bit;
  logic             br_new;
  logic             last_bit;
  logic [WIDTH-1:0] diff_shift;
  logic [WIDTH-1:0] diff_neg;

  // One full-subtract stage on the current LSB of the operand shift registers
  always_comb begin
    d_bit      = a_q[0] ^ b_q[0] ^ br_q;
    br_new     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    last_bit   = (cnt_q == LastCnt);
    diff_shift = diff_q >> 1;
    diff_shift[WIDTH-1] = d_bit;
    diff_neg   = ~diff_q + One;
  end

  // State register; synchronous reset clears all state and aborts any operation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StBusy;
      StBusy: begin
        if (last_bit) begin
`ifdef SERIAL_SUBTRACTOR_ABS_EN
          state_d = br_new ? StFix : StDone;
`else
          state_d = StDone;
`endif
        end
      end
      StFix:  state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: operand capture, bit-serial shift, result flags
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    br_d   = br_q;
    cnt_d  = cnt_q;
    diff_d = diff_q;
    bo_d   = bo_q;
    zero_d = zero_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          br_d  = borrow_in;
          cnt_d = '0;
        end
      end
      StBusy: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = br_new;
        diff_d = diff_shift;
        cnt_d  = cnt_q + 1'b1;
        if (last_bit) begin
          bo_d   = br_new;
          zero_d = (diff_shift == '0);
        end
      end
`ifdef SERIAL_SUBTRACTOR_ABS_EN
      StFix: begin
        // Two's-complement negate to report the magnitude
        diff_d = diff_neg;
        zero_d = (diff_neg == '0);
      end
`else
      StFix: ;
`endif
      StDone: ;
      default: ;
    endcase
  end

  // Outputs decoded from state; results come straight from their registers
  always_comb begin
    busy       = (state_q == StBusy) || (state_q == StFix);
    done       = (state_q == StDone);
    diff       = diff_q;
    borrow_out = bo_q;
    zero       = zero_q;
  end

`ifndef SERIAL_SUBTRACTOR_ABS_EN
  logic unused_neg;
  assign unused_neg = ^diff_neg;
`endif

endmodule
